// File: rtl/alu_pkg.sv
// Shared ALU definitions for the pipelined MIPS core.
// The control unit, the ALU-control decoder and the ALU all import this package.
package alu_pkg;

  // ALUOp classes issued by the control unit (4 bits)
  localparam logic [3:0] LOAD_STORE = 4'b0000;
  localparam logic [3:0] ADDI       = 4'b0001;
  localparam logic [3:0] R_TYPE     = 4'b0010;
  localparam logic [3:0] ANDI       = 4'b0100;
  localparam logic [3:0] ORI        = 4'b0101;
  localparam logic [3:0] BRANCH     = 4'b0111;
  localparam logic [3:0] XORI       = 4'b1000;
  localparam logic [3:0] LUI        = 4'b1001;
  localparam logic [3:0] SLTI       = 4'b1100;

  // ALU operation codes, using the MIPS funct encoding (6 bits)
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SLT = 6'b101010;
  localparam logic [5:0] OP_LUI = 6'b001111;

endpackage : alu_pkg

// File: rtl/alu_control.sv
// Registered ALU-control decoder (EX stage).
// Maps the control unit's ALUOp class, plus the funct field for R-type
// instructions, onto the operation code the ALU consumes. The result is
// registered so it lines up with the EX pipeline register.
module alu_control
  import alu_pkg::*;
#(
  parameter int NB_FUNCT  = 6,
  parameter int NB_ALU_OP = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NB_FUNCT-1:0]  i_op_r_tipe,
  input  logic [NB_ALU_OP-1:0] i_alu_op_CU,
  output logic [NB_FUNCT-1:0]  o_alu_control_signals
);

  logic [NB_FUNCT-1:0] alu_ctrl_d;
  logic [NB_FUNCT-1:0] alu_ctrl_q;

  // Decode the ALUOp class; funct is only looked at for R-type, so an
  // undriven funct on immediate instructions can never reach the output.
  always_comb begin
    alu_ctrl_d = NB_FUNCT'(OP_ADD);
    case (i_alu_op_CU)
      NB_ALU_OP'(LOAD_STORE): alu_ctrl_d = NB_FUNCT'(OP_ADD);
      NB_ALU_OP'(ADDI):       alu_ctrl_d = NB_FUNCT'(OP_ADD);
      NB_ALU_OP'(R_TYPE):     alu_ctrl_d = i_op_r_tipe;
      NB_ALU_OP'(ANDI):       alu_ctrl_d = NB_FUNCT'(OP_AND);
      NB_ALU_OP'(ORI):        alu_ctrl_d = NB_FUNCT'(OP_OR);
      NB_ALU_OP'(BRANCH):     alu_ctrl_d = NB_FUNCT'(OP_SUB);
      NB_ALU_OP'(XORI):       alu_ctrl_d = NB_FUNCT'(OP_XOR);
      NB_ALU_OP'(LUI):        alu_ctrl_d = NB_FUNCT'(OP_LUI);
      NB_ALU_OP'(SLTI):       alu_ctrl_d = NB_FUNCT'(OP_SLT);
      // Unassigned classes fall back to a harmless ADD
      default:                alu_ctrl_d = NB_FUNCT'(OP_ADD);
    endcase
  end

  // Output register; synchronous reset parks the ALU on ADD and wins over decode
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      alu_ctrl_q <= NB_FUNCT'(OP_ADD);
    end else begin
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

  assign o_alu_control_signals = alu_ctrl_q;

endmodule : alu_control

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed scenarios followed by
// randomized traffic, all checked against a table-driven reference model.
module tb_alu_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] funct;
  logic [3:0] alu_op;
  logic [5:0] alu_ctrl;

  int n_checks;
  int n_fail;

  // Reference: operation code for each of the 16 ALUOp values (R-type handled apart)
  logic [5:0] op_table [16];

  alu_control #(
    .NB_FUNCT  (6),
    .NB_ALU_OP (4)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_op_r_tipe           (funct),
    .i_alu_op_CU           (alu_op),
    .o_alu_control_signals (alu_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ref_decode(input logic [3:0] op, input logic [5:0] f);
    if (op == 4'd2) return f;
    return op_table[op];
  endfunction

  // Apply inputs, clock once, then check just after the edge and again at the
  // following falling edge to confirm the output held steady between edges.
  task automatic step(input string tag, input logic rst_v, input logic [3:0] op_v,
                      input logic [5:0] f_v, input logic [5:0] exp);
    rst_n  = rst_v;
    alu_op = op_v;
    funct  = f_v;
    @(posedge clk);
    #1;
    check_eq(tag, alu_ctrl, exp);
    @(negedge clk);
    check_eq({tag, "_hold"}, alu_ctrl, exp);
  endtask

  initial begin
    logic [3:0] iops   [8];
    logic [5:0] iexp   [8];
    logic [3:0] unused [4];
    logic [5:0] sweep  [6];
    logic [3:0] r_op;
    logic [5:0] r_f;
    logic       r_rst;

    n_checks = 0;
    n_fail   = 0;

    for (int i = 0; i < 16; i++) op_table[i] = 6'b100000;
    op_table[4'b0100] = 6'b100100;
    op_table[4'b0101] = 6'b100101;
    op_table[4'b0111] = 6'b100010;
    op_table[4'b1000] = 6'b100110;
    op_table[4'b1001] = 6'b001111;
    op_table[4'b1100] = 6'b101010;

    rst_n  = 1'b0;
    alu_op = 4'b0010;
    funct  = 6'b100100;
    @(negedge clk);

    // Reset held for two edges, then released
    step("reset_e1", 1'b0, 4'b0010, 6'b100100, 6'b100000);
    step("reset_e2", 1'b0, 4'b0010, 6'b100100, 6'b100000);
    step("release",  1'b1, 4'b0010, 6'b100100, 6'b100100);

    // R-type passthrough sweep
    sweep = '{6'b100000, 6'b100010, 6'b101010, 6'b000000, 6'b000011, 6'b001000};
    for (int i = 0; i < 6; i++)
      step($sformatf("rtype_%0d", i), 1'b1, 4'b0010, sweep[i], sweep[i]);

    // Immediate classes with funct left unknown
    iops = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1100, 4'b0111};
    iexp = '{6'b100000, 6'b100000, 6'b100100, 6'b100101, 6'b100110, 6'b001111,
             6'b101010, 6'b100010};
    for (int i = 0; i < 8; i++) begin
      step($sformatf("itype_%b", iops[i]), 1'b1, iops[i], 6'bxxxxxx, iexp[i]);
      n_checks++;
      if ($isunknown(alu_ctrl)) begin
        n_fail++;
        $display("FAIL itype_x_%b: observed %b expected no X", iops[i], alu_ctrl);
      end
    end

    // Unused ALUOp codes
    unused = '{4'b0011, 4'b0110, 4'b1010, 4'b1111};
    for (int i = 0; i < 4; i++)
      step($sformatf("unused_%b", unused[i]), 1'b1, unused[i], 6'b111111, 6'b100000);

    // Back-to-back class changes
    step("b2b_0", 1'b1, 4'b0010, 6'b100000, 6'b100000);
    step("b2b_1", 1'b1, 4'b0111, 6'b111111, 6'b100010);
    step("b2b_2", 1'b1, 4'b0100, 6'b000000, 6'b100100);
    step("b2b_3", 1'b1, 4'b0010, 6'b101010, 6'b101010);

    // Mid-stream reset while SLTI is presented
    step("mid_pre",   1'b1, 4'b1100, 6'b000000, 6'b101010);
    step("mid_rst",   1'b0, 4'b1100, 6'b000000, 6'b100000);
    step("mid_resume",1'b1, 4'b1100, 6'b000000, 6'b101010);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      r_op  = 4'($urandom_range(0, 15));
      r_f   = 6'($urandom_range(0, 63));
      r_rst = ($urandom_range(0, 19) != 0);
      step($sformatf("rand_%0d_op%b_f%b_r%0b", i, r_op, r_f, r_rst), r_rst, r_op, r_f,
           r_rst ? ref_decode(r_op, r_f) : 6'b100000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_control

// File: doc/alu_control.md
Name: alu_control

Overview:
- Registered ALU-control decoder in the EX stage of the pipelined MIPS core.
- Takes the 4-bit ALUOp from the control unit and the 6-bit R-type funct field.
- Produces the 6-bit operation code consumed by the ALU.
- Output updates one clock after its inputs, aligned with the EX pipeline register.

Parameters:
- NB_FUNCT, 6: width of the funct field and of the output operation code.
- NB_ALU_OP, 4: width of the ALUOp code from the control unit.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_op_r_tipe  input  NB_FUNCT  funct field (instr[5:0]); used only when ALUOp is R_TYPE.
- i_alu_op_CU  input  NB_ALU_OP  ALUOp class from the control unit.
- o_alu_control_signals  output  NB_FUNCT  registered ALU operation code.

Behaviour:
- Clocking and reset:
  - One clock domain (i_clk).
  - Reset is synchronous and active-low: on a rising edge with i_rst_n=0, o_alu_control_signals <= 6'b100000 (ADD).
- Latency: one cycle. Output at edge N+1 reflects the inputs sampled at edge N. No handshake; a new decode occurs every cycle.
- Operation codes (MIPS funct encoding): ADD=100000, SUB=100010, AND=100100, OR=100101, XOR=100110, SLT=101010, LUI=001111.
- ALUOp decode:
  - 0000 LOAD_STORE -> ADD
  - 0001 ADDI -> ADD
  - 0010 R_TYPE -> i_op_r_tipe passed through verbatim (all 64 values, including shifts, JR/JALR, unsigned variants)
  - 0100 ANDI -> AND
  - 0101 ORI -> OR
  - 0111 BRANCH -> SUB
  - 1000 XORI -> XOR
  - 1001 LUI -> LUI
  - 1100 SLTI -> SLT
  - All other ALUOp values (0011, 0110, 1010, 1011, 1101, 1110, 1111) -> ADD.
- Don't-care funct:
  - For every non-R_TYPE ALUOp, i_op_r_tipe is ignored. X/Z on it must not propagate to the output.
  - Decode via case on ALUOp only; no arithmetic on funct.
- Reset during operation:
  - Reset wins over decode on the same edge.
  - The first decode after release occurs on the first edge with i_rst_n=1.
- No internal state besides the output register.
- Combinational decode and register may be a single always block, or a comb block plus a flop.

Decomposition:
- Shared package/header alu_pkg holds:
  - the ALUOp localparams (LOAD_STORE, ADDI, R_TYPE, ANDI, ORI, BRANCH, XORI, LUI, SLTI);
  - the ALU operation codes (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_LUI).
- The control unit and the ALU import the same package.
- No sub-module; a single module is natural.

Test Plan:
- Reset: hold i_rst_n=0 for 2 edges with ALUOp=0010 and funct=100100. Output must be 100000. Release, then one edge later the output must be 100100.
- R-type passthrough: ALUOp=0010, funct sweeps 100000, 100010, 101010, 000000, 000011, 001000. Each value must appear on the output exactly one cycle later.
- I-type classes, with funct driven to X: 0000->100000, 0001->100000, 0100->100100, 0101->100101, 1000->100110, 1001->001111, 1100->101010, 0111->100010. The output must be free of X.
- Unused codes: ALUOp=0011, 0110, 1010, 1111 with funct=111111 -> output 100000.
- Latency and back-to-back: change ALUOp every cycle (0010/100000 -> 0111 -> 0100 -> 0010/101010).
  - Expected output sequence one cycle behind: 100000, 100010, 100100, 101010.
  - No glitch between edges.
- Mid-stream reset: assert i_rst_n=0 for one edge while ALUOp=1100. Output must be 100000 on that edge. Decode must resume (101010) on the next edge after release.
